// File: rtl/io_mmio_ctrl_if.sv
// io_mmio_ctrl_if: CPU data-port bus between the core and the MMIO controller
interface io_mmio_ctrl_if;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] wdata;
    logic        io_sel;
    logic [31:0] io_rdata;
    modport master (output addr, mem_read, mem_write, wdata, input io_sel, io_rdata);
    modport slave (input addr, mem_read, mem_write, wdata, output io_sel, io_rdata);
endinterface

// File: rtl/io_mmio_ctrl.sv
// io_mmio_ctrl: IO address decode, LED/switch/keypad registers and debounced hex keypad entry
module io_mmio_ctrl #(
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FC00,
    parameter logic [19:0] DEB_CYCLES = 20'd100_000,
    parameter int          MAX_DIGITS = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    io_mmio_ctrl_if.slave        bus,
    input  logic [23:0]          switch_i,
    input  logic [3:0]           key_val_i,
    input  logic                 key_pressed_i,
    output logic                 led_we_o,
    output logic [31:0]          led_data_o,
    output logic                 key_ready_o
);
    typedef enum logic [1:0] {IDLE, PRESS_DB, HOLD, RELEASE_DB} state_t;
    localparam logic [3:0]  MAXD     = 4'(MAX_DIGITS);
    localparam logic [19:0] DEB_LAST = DEB_CYCLES - 20'd1;

    state_t      state, state_n;
    logic [19:0] deb_cnt, deb_cnt_n;
    logic [3:0]  cap, cap_n;
    logic        accept;
    logic [31:0] ent_buf, key_data;
    logic [3:0]  dcount;

    assign bus.io_sel = bus.addr[31:8] == IO_BASE[31:8];
    wire is_led  = bus.io_sel && bus.addr[7:0] == 8'h60;
    wire is_sw   = bus.io_sel && bus.addr[7:0] == 8'h70;
    wire is_kd   = bus.io_sel && bus.addr[7:0] == 8'h74;
    wire is_ks   = bus.io_sel && bus.addr[7:0] == 8'h78;
    wire stat_wr = bus.mem_write && is_ks;
    wire data_rd = bus.mem_read && is_kd;
    wire acc_f   = accept && cap == 4'hF;
    wire acc_e   = accept && cap == 4'hE;
    wire acc_d   = accept && cap < 4'hE;

    always_comb begin
        bus.io_rdata = is_sw ? {8'd0, switch_i} :
                       is_kd ? key_data :
                       is_ks ? {27'd0, dcount, key_ready_o} : 32'd0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            deb_cnt <= '0;
            cap     <= '0;
        end else begin
            state   <= state_n;
            deb_cnt <= deb_cnt_n;
            cap     <= cap_n;
        end
    end

    // accept fires once, on the last stable cycle of the press debounce
    always_comb begin
        state_n   = state;
        deb_cnt_n = deb_cnt;
        cap_n     = cap;
        accept    = 1'b0;
        case (state)
            IDLE: if (key_pressed_i) begin
                state_n   = PRESS_DB;
                cap_n     = key_val_i;
                deb_cnt_n = '0;
            end
            PRESS_DB: if (!key_pressed_i) state_n = IDLE;
                else if (key_val_i != cap) begin
                    cap_n     = key_val_i;
                    deb_cnt_n = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    accept  = 1'b1;
                    state_n = HOLD;
                end else deb_cnt_n = deb_cnt + 20'd1;
            HOLD: if (!key_pressed_i) begin
                state_n   = RELEASE_DB;
                deb_cnt_n = '0;
            end
            RELEASE_DB: if (key_pressed_i) state_n = HOLD;
                else if (deb_cnt == DEB_LAST) state_n = IDLE;
                else deb_cnt_n = deb_cnt + 20'd1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            led_we_o    <= 1'b0;
            led_data_o  <= '0;
            key_ready_o <= 1'b0;
            key_data    <= '0;
            ent_buf     <= '0;
            dcount      <= '0;
        end else begin
            led_we_o <= bus.mem_write && is_led;
            if (bus.mem_write && is_led) led_data_o <= bus.wdata;
            if (acc_f) begin
                key_data    <= ent_buf;
                key_ready_o <= 1'b1;
                ent_buf     <= '0;
                dcount      <= '0;
            end else if (stat_wr) begin
                key_ready_o <= 1'b0;
                ent_buf     <= '0;
                dcount      <= '0;
            end else begin
                if (data_rd) key_ready_o <= 1'b0;
                if (acc_d && dcount < MAXD) begin
                    ent_buf <= {ent_buf[27:0], cap};
                    dcount  <= dcount + 4'd1;
                end
                if (acc_e && dcount != 4'd0) begin
                    ent_buf <= ent_buf >> 4;
                    dcount  <= dcount - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_io_mmio_ctrl.sv
// tb_io_mmio_ctrl: directed self-checking bench for io_mmio_ctrl with a short debounce
module tb_io_mmio_ctrl;
    localparam logic [31:0] BASE = 32'hFFFF_FC00;
    localparam logic [31:0] A_LED = BASE + 32'h60, A_SW = BASE + 32'h70;
    localparam logic [31:0] A_KD = BASE + 32'h74, A_KS = BASE + 32'h78;

    logic        clk_i = 1'b0, reset_i = 1'b1;
    logic [23:0] switch_i = '0;
    logic [3:0]  key_val_i = '0;
    logic        key_pressed_i = 1'b0;
    logic        led_we_o, key_ready_o;
    logic [31:0] led_data_o;
    int          vec = 0, err = 0;

    io_mmio_ctrl_if bus ();

    io_mmio_ctrl #(.IO_BASE(BASE), .DEB_CYCLES(20'd4), .MAX_DIGITS(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .bus(bus), .switch_i(switch_i),
        .key_val_i(key_val_i), .key_pressed_i(key_pressed_i),
        .led_we_o(led_we_o), .led_data_o(led_data_o), .key_ready_o(key_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk_i);
        bus.addr = a;
        bus.mem_read = 1'b1;
        #1 d = bus.io_rdata;
        @(negedge clk_i);
        bus.mem_read = 1'b0;
        bus.addr = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        bus.addr = a;
        bus.wdata = d;
        bus.mem_write = 1'b1;
        @(negedge clk_i);
        bus.mem_write = 1'b0;
        bus.addr = '0;
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk_i);
        key_val_i = k;
        key_pressed_i = 1'b1;
        repeat (10) @(negedge clk_i);
        key_pressed_i = 1'b0;
        repeat (10) @(negedge clk_i);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        press(4'hF);
        wr(A_LED, 32'hDEAD_BEEF);
        vec++; if (led_data_o !== 32'hDEAD_BEEF) begin err++; $display("FAIL pre_reset_led got %h exp %h", led_data_o, 32'hDEAD_BEEF); end
        @(negedge clk_i);
        key_val_i = 4'h5;
        key_pressed_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        vec++; if ({led_we_o, key_ready_o} !== 2'b00) begin err++; $display("FAIL reset_flags got %b exp 00", {led_we_o, key_ready_o}); end
        vec++; if (led_data_o !== 32'd0) begin err++; $display("FAIL reset_led got %h exp 0", led_data_o); end
        rd(A_KS, d);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL reset_stat got %h exp 0", d); end
        reset_i = 1'b0;
        rd(A_KS, d);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL early_accept got %h exp 0", d); end
        repeat (8) @(negedge clk_i);
        rd(A_KS, d);
        vec++; if (d !== 32'h2) begin err++; $display("FAIL held_after_reset got %h exp 2", d); end
        key_pressed_i = 1'b0;
        repeat (10) @(negedge clk_i);
        wr(A_KS, 32'd0);
        rd(A_KS, d);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL stat_write_clear got %h exp 0", d); end
    endtask

    task automatic test_led();
        wr(A_LED, 32'h000A_5A5A);
        vec++; if (led_we_o !== 1'b1) begin err++; $display("FAIL led_we_pulse got %b exp 1", led_we_o); end
        vec++; if (led_data_o !== 32'h000A_5A5A) begin err++; $display("FAIL led_data got %h exp %h", led_data_o, 32'h000A_5A5A); end
        @(negedge clk_i);
        vec++; if (led_we_o !== 1'b0) begin err++; $display("FAIL led_we_drop got %b exp 0", led_we_o); end
        wr(A_SW, 32'h1234_5678);
        vec++; if ({led_we_o, led_data_o} !== {1'b0, 32'h000A_5A5A}) begin err++; $display("FAIL sw_write_ignored got %b/%h exp 0/%h", led_we_o, led_data_o, 32'h000A_5A5A); end
        bus.addr = A_LED;
        #1;
        vec++; if (bus.io_sel !== 1'b1) begin err++; $display("FAIL io_sel_in got %b exp 1", bus.io_sel); end
        bus.addr = 32'hFFFF_FB60;
        #1;
        vec++; if (bus.io_sel !== 1'b0) begin err++; $display("FAIL io_sel_out got %b exp 0", bus.io_sel); end
        bus.addr = '0;
    endtask

    task automatic test_entry();
        logic [31:0] d;
        press(4'hE);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'hE);
        press(4'h4);
        rd(A_KS, d);
        vec++; if (d !== 32'h6) begin err++; $display("FAIL entry_count got %h exp 6", d); end
        press(4'hF);
        vec++; if (key_ready_o !== 1'b1) begin err++; $display("FAIL entry_ready got %b exp 1", key_ready_o); end
        rd(A_KD, d);
        vec++; if (d !== 32'h124) begin err++; $display("FAIL entry_data got %h exp 124", d); end
        vec++; if (key_ready_o !== 1'b0) begin err++; $display("FAIL read_clears_ready got %b exp 0", key_ready_o); end
        rd(A_KD, d);
        vec++; if (d !== 32'h124) begin err++; $display("FAIL data_held got %h exp 124", d); end
    endtask

    task automatic test_bounce();
        logic [31:0] d;
        key_val_i = 4'h7;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            key_pressed_i = ~key_pressed_i;
        end
        @(negedge clk_i);
        key_pressed_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rd(A_KS, d);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL bounce_rejected got %h exp 0", d); end
        press(4'h7);
        rd(A_KS, d);
        vec++; if (d !== 32'h2) begin err++; $display("FAIL bounce_one got %h exp 2", d); end
        press(4'hF);
        rd(A_KD, d);
        vec++; if (d !== 32'h7) begin err++; $display("FAIL bounce_data got %h exp 7", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        press(4'hF);
        rd(A_KS, d);
        vec++; if (d !== 32'h1) begin err++; $display("FAIL empty_enter got %h exp 1", d); end
        for (int i = 1; i <= 8; i++) press(4'(i));
        rd(A_KS, d);
        vec++; if (d !== 32'h11) begin err++; $display("FAIL stat_8 got %h exp 11", d); end
        press(4'h9);
        rd(A_KS, d);
        vec++; if (d !== 32'h11) begin err++; $display("FAIL stat_drop got %h exp 11", d); end
        press(4'hF);
        rd(A_KD, d);
        vec++; if (d !== 32'h1234_5678) begin err++; $display("FAIL overflow_data got %h exp 12345678", d); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        press(4'hA);
        press(4'hB);
        @(negedge clk_i);
        key_val_i = 4'hF;
        key_pressed_i = 1'b1;
        repeat (4) @(negedge clk_i);
        bus.addr = A_KD;
        bus.mem_read = 1'b1;
        @(negedge clk_i);
        bus.mem_read = 1'b0;
        vec++; if (key_ready_o !== 1'b1) begin err++; $display("FAIL collide_ready got %b exp 1", key_ready_o); end
        key_pressed_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rd(A_KD, d);
        vec++; if (d !== 32'hAB) begin err++; $display("FAIL collide_data got %h exp ab", d); end
        press(4'hD);
        @(negedge clk_i);
        key_val_i = 4'hC;
        key_pressed_i = 1'b1;
        repeat (4) @(negedge clk_i);
        bus.addr = A_KS;
        bus.wdata = 32'd0;
        bus.mem_write = 1'b1;
        @(negedge clk_i);
        bus.mem_write = 1'b0;
        key_pressed_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rd(A_KS, d);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL clear_wins got %h exp 0", d); end
        switch_i = 24'hABCDEF;
        rd(A_SW, d);
        vec++; if (d !== 32'h00AB_CDEF) begin err++; $display("FAIL sw_read got %h exp 00abcdef", d); end
        rd(BASE + 32'h64, d);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL unmapped_read got %h exp 0", d); end
        rd(32'h0000_0070, d);
        vec++; if (d !== 32'd0) begin err++; $display("FAIL outside_read got %h exp 0", d); end
    endtask

    initial begin
        bus.addr = '0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        test_reset();
        test_led();
        test_entry();
        test_bounce();
        test_overflow();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
